aes_key_expand: RTL and testbench

- Iterative AES key-schedule engine. It sits directly upstream of the inverse-cipher and cipher pipelines and feeds their round-key array input.
- It accepts a cipher key and generates one schedule word per clock. It holds the full 4*(Nr+1)-word schedule in registers and flags when the schedule is stable.
- Word and array ordering matches the consumers' round-key port, so the output connects without re-packing.

---
 rtl/aes_pkg.sv | 70 +++++++
 rtl/aes_key_expand.sv | 120 ++++++++++++
 tb/tb_aes_key_expand.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES helpers: S-box lookup, SubWord/RotWord, xtime, key-length encoding.
// Pure combinational functions; no latency of their own.
// No handshake: callers use these inside their own combinational logic.
package aes_pkg;

  // Words per state column group (block size in 32-bit words).
  localparam int Nb = 4;

  // Key length selector; nk_of() maps it to the number of key words.
  typedef enum logic [1:0] {
    AES128 = 2'd0,
    AES192 = 2'd1,
    AES256 = 2'd2
  } key_len_e;

  // Key-schedule engine states.
  typedef enum logic [1:0] {
    KS_IDLE   = 2'd0,
    KS_EXPAND = 2'd1,
    KS_DONE   = 2'd2
  } ks_state_e;

  function automatic int nk_of(input key_len_e kl);
    case (kl)
      AES192:  return 6;
      AES256:  return 8;
      default: return 4;
    endcase
  endfunction

  // Forward S-box, row-major: entry [x] holds S(x).
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Byte 0 of a word is its most significant byte.
  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // [a0,a1,a2,a3] -> [a1,a2,a3,a0]
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_expand.sv
// Iterative AES key schedule: one word per clock into a full round-key register array.
// Latency: key_ready rises 4*(Nr+1)-Nk cycles after the key_load edge (40/46/52).
// No backpressure: key_load is accepted in any state and restarts the schedule.
//
// Ports:
//   clk, rst_b      clock, asynchronous active-low reset
//   key_load, key   one-cycle start strobe and cipher key (word j = key[32*j +: 32])
//   busy            high while words are being generated
//   key_ready       high while rkey holds a complete, frozen schedule
//   rkey            schedule words, rkey[i] = w[i]
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6
) (
  input  logic                          clk,
  input  logic                          rst_b,
  input  logic                          key_load,
  input  logic [32*Nk-1:0]              key,
  output logic                          busy,
  output logic                          key_ready,
  output logic [Nb*(Nr+1)-1:0][31:0]    rkey
);

  localparam int NW = Nb * (Nr + 1);
  localparam int IW = $clog2(NW);
  localparam int WW = $clog2(Nk);

  localparam logic [IW-1:0] NK_IDX   = IW'(Nk);
  localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);
  localparam logic [WW-1:0] WRAP_MAX = WW'(Nk - 1);

  ks_state_e                 state_q, state_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [WW-1:0]             wrap_q, wrap_d;
  logic [7:0]                rcon_q, rcon_d;
  logic [NW-1:0][31:0]       rkey_q, rkey_d;

  logic [IW-1:0]             prev_idx;
  logic [IW-1:0]             back_idx;
  logic [31:0]               temp;
  logic [31:0]               new_word;

  // Word being produced is w[idx]; it depends on w[idx-1] and w[idx-Nk].
  // The clamps only matter outside EXPAND, where the result is unused.
  always_comb begin
    prev_idx = (idx_q != '0) ? idx_q - IW'(1) : '0;
    back_idx = (idx_q >= NK_IDX) ? idx_q - NK_IDX : '0;
  end

  // wrap_q tracks idx mod Nk so no divider is needed.
  always_comb begin
    temp = rkey_q[prev_idx];
    if (wrap_q == '0) begin
      temp = sub_word(rot_word(temp)) ^ {rcon_q, 24'h0};
    end else if ((Nk == 8) && (int'(wrap_q) == 4)) begin
      temp = sub_word(temp);
    end
    new_word = rkey_q[back_idx] ^ temp;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wrap_d  = wrap_q;
    rcon_d  = rcon_q;
    rkey_d  = rkey_q;

    if (key_load) begin
      // Restart from any state; words above Nk-1 keep stale contents until rewritten.
      for (int j = 0; j < Nk; j++) begin
        rkey_d[j] = key[32*j +: 32];
      end
      idx_d   = NK_IDX;
      wrap_d  = '0;
      rcon_d  = 8'h01;
      state_d = KS_EXPAND;
    end else begin
      case (state_q)
        KS_EXPAND: begin
          rkey_d[idx_q] = new_word;
          if (wrap_q == '0) begin
            rcon_d = xtime(rcon_q);
          end
          wrap_d = (wrap_q == WRAP_MAX) ? '0 : wrap_q + WW'(1);
          if (idx_q == LAST_IDX) begin
            state_d = KS_DONE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        default: begin
          // IDLE waits for a key; DONE holds the schedule frozen.
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= KS_IDLE;
      idx_q   <= '0;
      wrap_q  <= '0;
      rcon_q  <= 8'h01;
      rkey_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wrap_q  <= wrap_d;
      rcon_q  <= rcon_d;
      rkey_q  <= rkey_d;
    end
  end

  assign busy      = (state_q == KS_EXPAND);
  assign key_ready = (state_q == KS_DONE);
  assign rkey      = rkey_q;

endmodule

// File: tb/tb_aes_key_expand.sv
module tb_aes_key_expand;

  localparam logic [255:0] KEY_A1 = {128'h0,
    32'h09cf4f3c, 32'habf71588, 32'h28aed2a6, 32'h2b7e1516};
  localparam logic [255:0] KEY_A2 = {64'h0,
    32'h522c6b7b, 32'h62f8ead2, 32'h809079e5, 32'hc810f32b, 32'hda0e6452, 32'h8e73b0f7};
  localparam logic [255:0] KEY_A3 = {
    32'h0914dff4, 32'h2d9810a3, 32'h3b6108d7, 32'h1f352c07,
    32'h857d7781, 32'h2b73aef0, 32'h15ca71be, 32'h603deb10};

  logic clk;
  logic rst_b;
  logic         kl [3];
  logic [255:0] kk [3];
  logic busy4, busy6, busy8, rdy4, rdy6, rdy8;
  logic [43:0][31:0] rk4;
  logic [51:0][31:0] rk6;
  logic [59:0][31:0] rk8;

  int checks = 0;
  int errors = 0;

  aes_key_expand #(.Nk(4)) u_k4 (.clk(clk), .rst_b(rst_b), .key_load(kl[0]),
    .key(kk[0][127:0]), .busy(busy4), .key_ready(rdy4), .rkey(rk4));
  aes_key_expand #(.Nk(6)) u_k6 (.clk(clk), .rst_b(rst_b), .key_load(kl[1]),
    .key(kk[1][191:0]), .busy(busy6), .key_ready(rdy6), .rkey(rk6));
  aes_key_expand #(.Nk(8)) u_k8 (.clk(clk), .rst_b(rst_b), .key_load(kl[2]),
    .key(kk[2]), .busy(busy8), .key_ready(rdy8), .rkey(rk8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0] sbox_t [256];
  logic [7:0] rcon_t [10];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box derived from the field inverse plus the affine map.
  initial begin
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_t[x] = s;
    end
    rcon_t = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  end

  function automatic logic [31:0] sub_w(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic logic [59:0][31:0] expand(input int nk, input logic [255:0] key);
    logic [59:0][31:0] w;
    logic [31:0] t;
    w = '0;
    for (int j = 0; j < nk; j++) w[j] = key[32*j +: 32];
    for (int i = nk; i < 4*(nk+7); i++) begin
      t = w[i-1];
      if (i % nk == 0)
        t = sub_w({t[23:0], t[31:24]}) ^ {rcon_t[i/nk-1], 24'h0};
      else if (nk == 8 && i % nk == 4)
        t = sub_w(t);
      w[i] = w[i-nk] ^ t;
    end
    return w;
  endfunction

  function automatic int nk_n(input int n);  return 4 + 2*n;          endfunction
  function automatic int nw_n(input int n);  return 4 * (nk_n(n) + 7); endfunction

  // Visible words, busy/ready and progress per instance, advanced one word per edge.
  logic [31:0]       m_rkey  [3][60];
  logic [59:0][31:0] m_sched [3];
  int                m_cnt   [3];
  logic              m_busy  [3];
  logic              m_rdy   [3];

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int n = 0; n < 3; n++) begin
        for (int i = 0; i < 60; i++) m_rkey[n][i] <= 32'h0;
        m_busy[n] <= 1'b0;
        m_rdy[n]  <= 1'b0;
        m_cnt[n]  <= 0;
      end
    end else begin
      for (int n = 0; n < 3; n++) begin
        if (kl[n]) begin
          for (int j = 0; j < nk_n(n); j++) m_rkey[n][j] <= kk[n][32*j +: 32];
          m_sched[n] <= expand(nk_n(n), kk[n]);
          m_cnt[n]   <= nk_n(n);
          m_busy[n]  <= 1'b1;
          m_rdy[n]   <= 1'b0;
        end else if (m_busy[n]) begin
          m_rkey[n][m_cnt[n]] <= m_sched[n][m_cnt[n]];
          m_cnt[n] <= m_cnt[n] + 1;
          if (m_cnt[n] == nw_n(n) - 1) begin
            m_busy[n] <= 1'b0;
            m_rdy[n]  <= 1'b1;
          end
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input int n, input int i,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s nk=%0d idx=%0d: got %08h want %08h", nm, nk_n(n), i, act, exp);
    end
  endtask

  function automatic logic [31:0] dut_word(input int n, input int i);
    case (n)
      0:       return (i < 44) ? rk4[i] : 32'h0;
      1:       return (i < 52) ? rk6[i] : 32'h0;
      default: return rk8[i];
    endcase
  endfunction

  function automatic logic dut_busy(input int n);
    return (n == 0) ? busy4 : (n == 1) ? busy6 : busy8;
  endfunction

  function automatic logic dut_rdy(input int n);
    return (n == 0) ? rdy4 : (n == 1) ? rdy6 : rdy8;
  endfunction

  always @(negedge clk) begin
    for (int n = 0; n < 3; n++) begin
      chk("busy", n, 0, {31'h0, dut_busy(n)}, {31'h0, m_busy[n]});
      chk("key_ready", n, 0, {31'h0, dut_rdy(n)}, {31'h0, m_rdy[n]});
      chk("both_high", n, 0, {31'h0, dut_busy(n) & dut_rdy(n)}, 32'h0);
      for (int i = 0; i < nw_n(n); i++)
        chk("rkey", n, i, dut_word(n, i), m_rkey[n][i]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string nm);
    for (int n = 0; n < 3; n++) begin
      chk({nm, "_busy"}, n, 0, {31'h0, dut_busy(n)}, 32'h0);
      chk({nm, "_ready"}, n, 0, {31'h0, dut_rdy(n)}, 32'h0);
      for (int i = 0; i < nw_n(n); i++) chk({nm, "_rkey"}, n, i, dut_word(n, i), 32'h0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [59:0][31:0] e;
    logic [255:0] nkey;
    int lat [3];
    int c;

    rst_b = 1'b0;
    for (int n = 0; n < 3; n++) begin kl[n] = 1'b0; kk[n] = '0; end
    repeat (3) tick();
    check_all_zero("reset");
    rst_b = 1'b1;
    tick();

    // Pin the model to published vectors.
    e = expand(4, KEY_A1);
    chk("model_a1_w4", 0, 4, e[4], 32'ha0fafe17);
    chk("model_a1_w40", 0, 40, e[40], 32'hd014f9a8);
    chk("model_a1_w43", 0, 43, e[43], 32'hb6630ca6);
    e = expand(6, KEY_A2);
    chk("model_a2_w51", 1, 51, e[51], 32'h01002202);
    e = expand(8, KEY_A3);
    chk("model_a3_w59", 2, 59, e[59], 32'h706c631e);
    e = expand(4, '0);
    chk("model_zero_w40", 0, 40, e[40], 32'hb4ef5bcb);

    // Published vectors on all three widths at once; key bus scrambled after load.
    kk[0] = KEY_A1; kk[1] = KEY_A2; kk[2] = KEY_A3;
    for (int n = 0; n < 3; n++) begin kl[n] = 1'b1; lat[n] = -1; end
    tick();
    for (int n = 0; n < 3; n++) begin
      kl[n] = 1'b0;
      kk[n] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    end
    for (c = 1; c <= 70; c++) begin
      tick();
      for (int n = 0; n < 3; n++) if (dut_rdy(n) && lat[n] < 0) lat[n] = c;
    end
    for (int n = 0; n < 3; n++) chk("latency", n, 0, lat[n], 4*(nk_n(n)+7) - nk_n(n));
    chk("a1_w4", 0, 4, rk4[4], 32'ha0fafe17);
    chk("a1_w40", 0, 40, rk4[40], 32'hd014f9a8);
    chk("a1_w41", 0, 41, rk4[41], 32'hc9ee2589);
    chk("a1_w42", 0, 42, rk4[42], 32'he13f0cc8);
    chk("a1_w43", 0, 43, rk4[43], 32'hb6630ca6);
    chk("a2_w51", 1, 51, rk6[51], 32'h01002202);
    chk("a3_w59", 2, 59, rk8[59], 32'h706c631e);

    // Restart mid-expansion with an all-zero key.
    kk[0] = KEY_A1; kl[0] = 1'b1;
    tick();
    kl[0] = 1'b0;
    repeat (9) tick();
    kk[0] = '0; kl[0] = 1'b1;
    tick();
    kl[0] = 1'b0;
    c = 0;
    while (!rdy4 && c < 100) begin
      chk("restart_busy", 0, c, {31'h0, busy4}, 32'h1);
      tick();
      c++;
    end
    chk("restart_latency", 0, 0, c, 40);
    chk("zero_w40", 0, 40, rk4[40], 32'hb4ef5bcb);

    // Reload while DONE.
    nkey = {128'h0, $urandom, $urandom, $urandom, $urandom};
    kk[0] = nkey; kl[0] = 1'b1;
    tick();
    kl[0] = 1'b0;
    chk("reload_ready", 0, 0, {31'h0, rdy4}, 32'h0);
    chk("reload_busy", 0, 0, {31'h0, busy4}, 32'h1);
    for (int j = 0; j < 4; j++) chk("reload_key", 0, j, rk4[j], nkey[32*j +: 32]);
    for (int k = 0; k < 39; k++) begin
      tick();
      chk("reload_ready_low", 0, k, {31'h0, rdy4}, 32'h0);
    end
    tick();
    chk("reload_ready_rise", 0, 0, {31'h0, rdy4}, 32'h1);

    // Random keys, random (re)loads in every state, key bus churning every cycle.
    repeat (800) begin
      for (int n = 0; n < 3; n++) begin
        kl[n] = ($urandom_range(0, 39) == 0);
        kk[n] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      end
      tick();
    end
    for (int n = 0; n < 3; n++) kl[n] = 1'b0;
    repeat (60) tick();

    // Asynchronous reset twenty cycles into a schedule.
    kk[0] = KEY_A1; kk[1] = KEY_A2; kk[2] = KEY_A3;
    for (int n = 0; n < 3; n++) kl[n] = 1'b1;
    tick();
    for (int n = 0; n < 3; n++) kl[n] = 1'b0;
    repeat (19) tick();
    #2 rst_b = 1'b0;
    #1 check_all_zero("async_reset");
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b1;
    repeat (30) tick();
    check_all_zero("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
